// File: rtl/sbox_array.sv
// sbox_array: LANES parallel AES S-box lookups with one registered output stage.
// Define SBOX_INV_EN to build the inverse S-box and honour in_inv.
module sbox_array #(
  parameter int LANES = 4,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef SBOX_INV_EN
  localparam logic [7:0] ISBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
`endif

  logic               r_valid;
  logic [8*LANES-1:0] r_data;
  logic [TAG_W-1:0]   r_tag;
  logic               r_err;

  logic [8*LANES-1:0] w_sub;
  logic               w_err;
  logic               w_accept;
  logic               w_deliver;

  assign in_ready  = !r_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_deliver = r_valid && out_ready;

  // Per-lane lookup; lanes are fully independent tables.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
`ifdef SBOX_INV_EN
    assign w_sub[8*g +: 8] = in_inv ? ISBOX[in_data[8*g +: 8]]
                                    : SBOX[in_data[8*g +: 8]];
`else
    assign w_sub[8*g +: 8] = SBOX[in_data[8*g +: 8]];
`endif
  end

  // Inverse requests can only be flagged when no inverse table exists.
`ifdef SBOX_INV_EN
  assign w_err = 1'b0;
`else
  assign w_err = in_inv;
`endif

  // Single output slot: load on accept, empty on a bare deliver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_tag   <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= w_sub;
      r_tag   <= in_tag;
      r_err   <= w_err;
    end else if (w_deliver) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_tag   = r_tag;
  assign out_err   = r_err;

endmodule

// File: tb/tb_sbox_array.sv
// tb_sbox_array: randomized self-checking bench for sbox_array.
// Reference S-box is derived from GF(2^8) inversion plus the AES affine map.
module tb_sbox_array;

  localparam int L = 4;
  localparam int T = 4;
`ifdef SBOX_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [8*L-1:0] in_data;
  logic           in_inv;
  logic [T-1:0]   in_tag;
  logic           out_valid;
  logic           out_ready;
  logic [8*L-1:0] out_data;
  logic [T-1:0]   out_tag;
  logic           out_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  sbox_array #(.LANES(L), .TAG_W(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_err(out_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] iv;
    for (int x = 0; x < 256; x++) begin
      iv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      fwd_t[x] = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3)
                 ^ rotl(iv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);
  endtask

  function automatic logic [8*L-1:0] ref_sub(input logic [8*L-1:0] d,
                                             input logic inv);
    logic [8*L-1:0] r;
    for (int i = 0; i < L; i++)
      r[8*i +: 8] = (inv && INV_EN) ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = $urandom();
    in_inv = 1'b1;
    in_tag = 4'hA;
    out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    checks++;
    if (out_data !== '0 || out_tag !== '0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: got %h/%h/%b want 0/0/0", out_data, out_tag, out_err);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_inv = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_vector();
    in_valid = 1'b1;
    in_data = 32'hff53_0100;
    in_inv = 1'b0;
    in_tag = 4'h5;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h16ed_7c63) begin
      errors++;
      $display("FAIL vector_data: got v=%b %h want v=1 16ed7c63", out_valid, out_data);
    end
    checks++;
    if (out_tag !== 4'h5 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL vector_tag: got %h/%b want 5/0", out_tag, out_err);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h16ed_7c63) begin
      errors++;
      $display("FAIL vector_drain: got v=%b %h want v=0 16ed7c63", out_valid, out_data);
    end
  endtask

  task automatic test_inverse();
    in_valid = 1'b1;
    in_inv = 1'b1;
    in_tag = 4'h2;
    in_data = INV_EN ? 32'h0063_ed16 : 32'h0000_0000;
    tick();
    checks++;
    if (INV_EN && (out_data !== 32'h5200_53ff || out_err !== 1'b0)) begin
      errors++;
      $display("FAIL inv_vector: got %h/%b want 520053ff/0", out_data, out_err);
    end else if (!INV_EN && (out_data !== 32'h6363_6363 || out_err !== 1'b1)) begin
      errors++;
      $display("FAIL inv_disabled: got %h/%b want 63636363/1", out_data, out_err);
    end
    in_inv = 1'b0;
    in_data = 32'h0102_0304;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_err !== 1'b0 || out_data !== 32'h7c77_7bf2) begin
      errors++;
      $display("FAIL inv_clear: got %h/%b want 7c777bf2/0", out_data, out_err);
    end
    tick();
  endtask

  task automatic test_all_values();
    logic [8*L-1:0] d;
    logic [8*L-1:0] f;
    logic [8*L-1:0] exp_rt;
    int bad_f = 0;
    int bad_r = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 256 / L; k++) begin
      for (int i = 0; i < L; i++) d[8*i +: 8] = 8'(k * L + i);
      in_valid = 1'b1;
      in_inv = 1'b0;
      in_data = d;
      tick();
      f = out_data;
      if (out_data !== ref_sub(d, 1'b0) || out_err !== 1'b0) bad_f++;
      in_inv = 1'b1;
      in_data = f;
      tick();
      exp_rt = INV_EN ? d : ref_sub(f, 1'b0);
      if (out_data !== exp_rt || out_err !== !INV_EN) bad_r++;
    end
    in_valid = 1'b0;
    in_inv = 1'b0;
    tick();
    checks++;
    if (bad_f != 0) begin
      errors++; $display("FAIL all_forward: got %0d bad groups want 0", bad_f);
    end
    checks++;
    if (bad_r != 0) begin
      errors++; $display("FAIL all_roundtrip: got %0d bad groups want 0", bad_r);
    end
  endtask

  task automatic test_backpressure();
    logic [8*L-1:0] a = $urandom();
    logic [8*L-1:0] b = $urandom();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_inv = 1'b0;
    in_data = a;
    in_tag = 4'h9;
    tick();
    in_data = b;
    in_tag = 4'h3;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== ref_sub(a, 1'b0)
          || out_tag !== 4'h9) begin
        errors++;
        $display("FAIL hold_%0d: got r=%b v=%b %h/%h want r=0 v=1 %h/9",
                 c, in_ready, out_valid, out_data, out_tag, ref_sub(a, 1'b0));
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL release_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== ref_sub(b, 1'b0) || out_tag !== 4'h3) begin
      errors++;
      $display("FAIL release_next: got v=%b %h/%h want v=1 %h/3",
               out_valid, out_data, out_tag, ref_sub(b, 1'b0));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [8*L-1:0] d [16];
    int bad = 0;
    out_ready = 1'b1;
    in_inv = 1'b0;
    for (int k = 0; k < 16; k++) d[k] = $urandom();
    in_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_data = d[k];
      in_tag = 4'(k);
      if (in_ready !== 1'b1) bad++;
      tick();
      if (out_valid !== 1'b1 || out_tag !== 4'(k) || out_data !== ref_sub(d[k], 1'b0))
        bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stream: got %0d bad cycles want 0", bad);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_end: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    logic           m_valid = 1'b0;
    logic [8*L-1:0] m_data = '0;
    logic [T-1:0]   m_tag = '0;
    logic           m_err = 1'b0;
    logic [8*L-1:0] m_prev;
    int bad = 0;
    int delivered = 0;
    int accepted = 0;
    m_prev = out_data;
    m_data = m_prev;
    m_tag = out_tag;
    m_err = out_err;
    for (int c = 0; c < 400; c++) begin
      in_valid = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data = $urandom();
      in_inv = $urandom_range(0, 1);
      in_tag = 4'($urandom());
      #1;
      if (in_ready !== (!m_valid || out_ready)) bad++;
      if (in_valid && (!m_valid || out_ready)) begin
        accepted++;
        if (m_valid && out_ready) delivered++;
        m_valid = 1'b1;
        m_data = ref_sub(in_data, in_inv);
        m_tag = in_tag;
        m_err = in_inv && !INV_EN;
      end else if (m_valid && out_ready) begin
        delivered++;
        m_valid = 1'b0;
      end
      tick();
      if (out_valid !== m_valid || out_data !== m_data || out_tag !== m_tag
          || out_err !== m_err) bad++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL random: got %0d bad cycles want 0", bad);
    end
    checks++;
    if (accepted - delivered != (m_valid ? 1 : 0) || accepted == 0) begin
      errors++;
      $display("FAIL random_count: got acc=%0d del=%0d", accepted, delivered);
    end
  endtask

  task automatic test_async_reset();
    logic [8*L-1:0] y = $urandom();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_inv = 1'b0;
    in_data = 32'hdead_beef;
    in_tag = 4'h7;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'h7) begin
      errors++; $display("FAIL areset_pre: got v=%b t=%h want 1/7", out_valid, out_tag);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0) begin
      errors++;
      $display("FAIL areset_clear: got v=%b %h/%h want 0 0/0", out_valid, out_data, out_tag);
    end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = y;
    in_tag = 4'hC;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== ref_sub(y, 1'b0) || out_tag !== 4'hC) begin
      errors++;
      $display("FAIL areset_after: got v=%b %h/%h want 1 %h/c",
               out_valid, out_data, out_tag, ref_sub(y, 1'b0));
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_inv = 1'b0;
    in_tag = '0;
    out_ready = 1'b0;
    build_tables();
    test_reset();
    test_vector();
    test_inverse();
    test_all_values();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
